// File: rtl/stdp_pkg.sv
// STDP synapse shared constants.
// Window, amplitude bins and the A(dt) lookup.
package stdp_pkg;

    localparam logic [7:0] W_INIT_DEF = 8'd128;
    localparam int         WINDOW_DEF = 16;

    localparam logic [7:0] A_BIN0 = 8'd16;
    localparam logic [7:0] A_BIN1 = 8'd8;
    localparam logic [7:0] A_BIN2 = 8'd4;
    localparam logic [7:0] A_BIN3 = 8'd2;

    localparam logic [7:0] DT_BIN1    = 8'd4;
    localparam logic [7:0] DT_BIN2    = 8'd8;
    localparam logic [7:0] DT_BIN3    = 8'd12;
    localparam logic [7:0] DT_BIN_END = 8'd16;

    function automatic logic [7:0] stdp_amp(input logic [7:0] dt);
        logic [7:0] a;
        a = 8'd0;
        if (dt == 8'd0)
            a = 8'd0;
        else if (dt < DT_BIN1)
            a = A_BIN0;
        else if (dt < DT_BIN2)
            a = A_BIN1;
        else if (dt < DT_BIN3)
            a = A_BIN2;
        else if (dt < DT_BIN_END)
            a = A_BIN3;
        return a;
    endfunction

endpackage

// File: rtl/stdp_synapse_if.sv
// STDP synapse signal bundle.
// Master drives spikes and load, slave returns weight.
interface stdp_synapse_if;

    logic       pre_spike;
    logic       post_spike;
    logic       learn_en;
    logic       w_load;
    logic [7:0] w_load_val;
    logic [7:0] weight;
    logic       w_upd;
    logic       dw_dir;
    logic [3:0] time_diff;

    modport master (
        output pre_spike,
        output post_spike,
        output learn_en,
        output w_load,
        output w_load_val,
        input  weight,
        input  w_upd,
        input  dw_dir,
        input  time_diff
    );

    modport slave (
        input  pre_spike,
        input  post_spike,
        input  learn_en,
        input  w_load,
        input  w_load_val,
        output weight,
        output w_upd,
        output dw_dir,
        output time_diff
    );

endinterface

// File: rtl/stdp_trace.sv
// Spike trace: saturating age counter with live flag.
// A trace stays pairable until consumed or aged out.
module stdp_trace
    import stdp_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int AW     = $clog2(WINDOW + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spike,
    input  logic          consume,
    input  logic          clear,
    output logic          live,
    output logic [AW-1:0] dt
);

    localparam logic [AW-1:0] AGE_MAX = AW'(WINDOW);

    logic [AW-1:0] age;
    logic          valid;

    // Age restarts on a spike; otherwise counts up to the expired value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            age   <= AGE_MAX;
            valid <= 1'b0;
        end else if (spike) begin
            age   <= '0;
            valid <= 1'b1;
        end else begin
            if (age < AGE_MAX)
                age <= age + AW'(1);
            if (consume)
                valid <= 1'b0;
        end
    end

    // dt as seen by a spike sampled on the coming edge.
    assign dt   = age + AW'(1);
    assign live = valid && (dt < AGE_MAX);

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse with nearest-neighbour pairing.
// Saturating 8-bit weight, one-cycle update latency.
module stdp_synapse
    import stdp_pkg::*;
#(
    parameter logic [7:0] W_INIT = W_INIT_DEF,
    parameter int         WINDOW = WINDOW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    stdp_synapse_if.slave  bus
);

    localparam int AW = $clog2(WINDOW + 2);

    logic          pre_live;
    logic          post_live;
    logic [AW-1:0] pre_dt;
    logic [AW-1:0] post_dt;
    logic          pot;
    logic          dep;
    logic [AW-1:0] sel_dt;
    logic [7:0]    amp;
    logic [8:0]    sum;
    logic [8:0]    diff;
    logic [7:0]    w_next;

    logic [7:0]    weight_q;
    logic          w_upd_q;
    logic          dir_q;
    logic [3:0]    td_q;

    stdp_trace #(
        .WINDOW (WINDOW),
        .AW     (AW)
    ) u_pre_trace (
        .clk     (clk),
        .rst     (rst),
        .spike   (bus.pre_spike),
        .consume (pot),
        .clear   (bus.w_load),
        .live    (pre_live),
        .dt      (pre_dt)
    );

    stdp_trace #(
        .WINDOW (WINDOW),
        .AW     (AW)
    ) u_post_trace (
        .clk     (clk),
        .rst     (rst),
        .spike   (bus.post_spike),
        .consume (dep),
        .clear   (bus.w_load),
        .live    (post_live),
        .dt      (post_dt)
    );

    // Pair detection and saturating weight arithmetic.
    always_comb begin
        pot = bus.learn_en && !bus.w_load
            && bus.post_spike && !bus.pre_spike
            && pre_live;
        dep = bus.learn_en && !bus.w_load
            && bus.pre_spike && !bus.post_spike
            && post_live;
        sel_dt = pot ? pre_dt : post_dt;
        amp    = stdp_amp(8'(sel_dt));
        sum    = {1'b0, weight_q} + {1'b0, amp};
        diff   = {1'b0, weight_q} - {1'b0, amp};
        w_next = weight_q;
        if (pot)
            w_next = sum[8] ? 8'hFF : sum[7:0];
        else if (dep)
            w_next = diff[8] ? 8'h00 : diff[7:0];
    end

    // Weight and update-status registers; load beats learning.
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_q <= W_INIT;
            w_upd_q  <= 1'b0;
            dir_q    <= 1'b0;
            td_q     <= 4'd0;
        end else if (bus.w_load) begin
            weight_q <= bus.w_load_val;
            w_upd_q  <= 1'b0;
        end else begin
            weight_q <= w_next;
            w_upd_q  <= pot | dep;
            if (pot | dep) begin
                dir_q <= pot;
                td_q  <= 4'(sel_dt);
            end
        end
    end

    assign bus.weight    = weight_q;
    assign bus.w_upd     = w_upd_q;
    assign bus.dw_dir    = dir_q;
    assign bus.time_diff = td_q;

endmodule

// File: tb/tb_stdp_synapse.sv
// Self-checking bench for stdp_synapse.
// Vector table, corner sequences and random traffic vs a timestamp model.
module tb_stdp_synapse;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stdp_synapse_if bus ();

    stdp_synapse #(
        .W_INIT (8'd128),
        .WINDOW (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: spike timestamps and pairing eligibility.
    int t         = 0;
    int last_pre  = -1000;
    int last_post = -1000;
    bit pre_ok    = 1'b0;
    bit post_ok   = 1'b0;
    int m_w       = 128;
    int m_upd     = 0;
    int m_dir     = 0;
    int m_td      = 0;

    function automatic int amp_ref(input int d);
        if (d >= 1 && d <= 3)
            return 16;
        if (d >= 4 && d <= 7)
            return 8;
        if (d >= 8 && d <= 11)
            return 4;
        if (d >= 12 && d <= 15)
            return 2;
        return 0;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit q,
                              input bit l, input bit wl, input int wv);
        int d;
        if (r) begin
            m_w = 128; m_upd = 0; m_dir = 0; m_td = 0;
            pre_ok = 0; post_ok = 0;
        end else if (wl) begin
            m_w = wv; m_upd = 0;
            pre_ok = 0; post_ok = 0;
        end else begin
            m_upd = 0;
            if (q && !p && l && pre_ok && (t - last_pre) < 16) begin
                d = t - last_pre;
                m_w = m_w + amp_ref(d);
                if (m_w > 255) m_w = 255;
                m_upd = 1; m_dir = 1; m_td = d;
                pre_ok = 0;
            end else if (p && !q && l && post_ok && (t - last_post) < 16) begin
                d = t - last_post;
                m_w = m_w - amp_ref(d);
                if (m_w < 0) m_w = 0;
                m_upd = 1; m_dir = 0; m_td = d;
                post_ok = 0;
            end
            if (p) begin last_pre = t; pre_ok = 1; end
            if (q) begin last_post = t; post_ok = 1; end
        end
        t++;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic cycle(input bit r, input bit p, input bit q,
                         input bit l, input bit wl, input logic [7:0] wv);
        rst            = r;
        bus.pre_spike  = p;
        bus.post_spike = q;
        bus.learn_en   = l;
        bus.w_load     = wl;
        bus.w_load_val = wv;
        @(posedge clk);
        model_step(r, p, q, l, wl, int'(wv));
        #1;
        check("model_weight", 32'(bus.weight), 32'(m_w));
        check("model_w_upd", 32'(bus.w_upd), 32'(m_upd));
        check("model_dw_dir", 32'(bus.dw_dir), 32'(m_dir));
        check("model_time_diff", 32'(bus.time_diff), 32'(m_td));
    endtask

    task automatic idle(input int n, input bit l);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'b0, l, 1'b0, 8'd0);
    endtask

    task automatic load(input logic [7:0] v);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, v);
    endtask

    task automatic pair(input bit pre_first, input int d, input bit l);
        cycle(1'b0, pre_first, !pre_first, l, 1'b0, 8'd0);
        idle(d - 1, l);
        cycle(1'b0, !pre_first, pre_first, l, 1'b0, 8'd0);
    endtask

    typedef struct {
        logic [7:0] ld;
        bit         same;
        bit         pre_first;
        int         dt;
        bit         learn;
        logic [7:0] exp_w;
        bit         exp_upd;
        bit         exp_dir;
        logic [3:0] exp_td;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{8'd128, 0, 1, 3,  1, 8'd144, 1, 1, 4'd3};
        vecs[1]  = '{8'd128, 0, 0, 5,  1, 8'd120, 1, 0, 4'd5};
        vecs[2]  = '{8'd250, 0, 1, 2,  1, 8'd255, 1, 1, 4'd2};
        vecs[3]  = '{8'd3,   0, 0, 12, 1, 8'd1,   1, 0, 4'd12};
        vecs[4]  = '{8'd1,   0, 0, 12, 1, 8'd0,   1, 0, 4'd12};
        vecs[5]  = '{8'd128, 1, 1, 1,  1, 8'd128, 0, 0, 4'd0};
        vecs[6]  = '{8'd128, 0, 1, 16, 1, 8'd128, 0, 0, 4'd0};
        vecs[7]  = '{8'd128, 0, 1, 3,  0, 8'd128, 0, 0, 4'd0};
        vecs[8]  = '{8'd100, 0, 1, 15, 1, 8'd102, 1, 1, 4'd15};
        vecs[9]  = '{8'd100, 0, 0, 1,  1, 8'd84,  1, 0, 4'd1};
        vecs[10] = '{8'd100, 0, 1, 8,  1, 8'd104, 1, 1, 4'd8};
        vecs[11] = '{8'd255, 0, 1, 1,  1, 8'd255, 1, 1, 4'd1};
        vecs[12] = '{8'd10,  0, 0, 4,  1, 8'd2,   1, 0, 4'd4};

        // Reset for two cycles.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd7);
        check("reset_weight", 32'(bus.weight), 32'd128);
        check("reset_w_upd", 32'(bus.w_upd), 32'd0);
        check("reset_time_diff", 32'(bus.time_diff), 32'd0);

        // Table of single pairs from a loaded weight.
        for (int i = 0; i < 13; i++) begin
            load(vecs[i].ld);
            idle(20, 1'b1);
            if (vecs[i].same)
                cycle(1'b0, 1'b1, 1'b1, vecs[i].learn, 1'b0, 8'd0);
            else
                pair(vecs[i].pre_first, vecs[i].dt, vecs[i].learn);
            check($sformatf("vec%0d_weight", i), 32'(bus.weight),
                  32'(vecs[i].exp_w));
            check($sformatf("vec%0d_w_upd", i), 32'(bus.w_upd),
                  32'(vecs[i].exp_upd));
            if (vecs[i].exp_upd) begin
                check($sformatf("vec%0d_dw_dir", i), 32'(bus.dw_dir),
                      32'(vecs[i].exp_dir));
                check($sformatf("vec%0d_time_diff", i), 32'(bus.time_diff),
                      32'(vecs[i].exp_td));
            end
            idle(1, 1'b1);
            check($sformatf("vec%0d_pulse_end", i), 32'(bus.w_upd), 32'd0);
        end

        // Post then pre at +5, then a second pre at +7 finds post consumed.
        load(8'd128);
        idle(20, 1'b1);
        pair(1'b0, 5, 1'b1);
        check("consume_first_w", 32'(bus.weight), 32'd120);
        idle(1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        check("consume_second_w", 32'(bus.weight), 32'd120);
        check("consume_second_upd", 32'(bus.w_upd), 32'd0);

        // Two fresh depressions with dt=12 from weight 3.
        load(8'd3);
        idle(20, 1'b1);
        pair(1'b0, 12, 1'b1);
        check("sat_low_first", 32'(bus.weight), 32'd1);
        idle(20, 1'b1);
        pair(1'b0, 12, 1'b1);
        check("sat_low_second", 32'(bus.weight), 32'd0);
        check("sat_low_upd", 32'(bus.w_upd), 32'd1);

        // Reset mid-window discards the pending pre trace.
        idle(20, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check("rst_mid_weight", 32'(bus.weight), 32'd128);
        check("rst_mid_upd", 32'(bus.w_upd), 32'd0);

        // Load in the same cycle as a pairing spike wins and clears traces.
        idle(20, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd50);
        check("load_prio_weight", 32'(bus.weight), 32'd50);
        check("load_prio_upd", 32'(bus.w_upd), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        check("load_clear_weight", 32'(bus.weight), 32'd50);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 149) == 0,
                  8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
